// File: rtl/conv_load_sched_if.sv
// Control/handshake/SRAM bundle between the conv load scheduler and its core/memory.
// The scheduler uses the slave modport; the driver of start/abort/req uses master.
interface conv_load_sched_if;
  logic        start;
  logic        abort;
  logic [1:0]  req;
  logic [1:0]  ack;
  logic        inst_wload;
  logic        sfu_acc;
  logic        mem_CEN;
  logic        mem_WEN;
  logic [10:0] mem_A;
  logic        busy;
  logic        done;

  modport slave (
    input  start, abort, req,
    output ack, inst_wload, sfu_acc, mem_CEN, mem_WEN, mem_A, busy, done
  );

  modport master (
    output start, abort, req,
    input  ack, inst_wload, sfu_acc, mem_CEN, mem_WEN, mem_A, busy, done
  );
endinterface

// File: rtl/conv_load_sched.sv
// Sequences one convolution pass: per kij a weight block read, an activation window read,
// a flush and a settle gap; then one SFU accumulate pulse, a drain wait and a done pulse.
module conv_load_sched #(
  parameter int          LEN_NI       = 6,
  parameter int          LEN_NI_UNPAD = 4,
  parameter int          LEN_KI       = 3,
  parameter int          CHANNELS     = 8,
  parameter logic [10:0] W_BASE       = 11'h400,
  parameter int          SETTLE_CYC   = 20,
  parameter int          DRAIN_CYC    = 200
) (
  input  logic              clk,
  input  logic              reset,
  conv_load_sched_if.slave  bus
);
  localparam int KIJ_N   = LEN_KI * LEN_KI;
  localparam int CNT_MAX = (CHANNELS > SETTLE_CYC)
                         ? ((CHANNELS > DRAIN_CYC) ? CHANNELS : DRAIN_CYC)
                         : ((SETTLE_CYC > DRAIN_CYC) ? SETTLE_CYC : DRAIN_CYC);
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int KW      = $clog2(KIJ_N + 1);
  localparam int KXW     = $clog2(LEN_KI + 1);
  localparam int PW      = $clog2(LEN_NI_UNPAD + 1);

  typedef enum logic [3:0] {
    IDLE, WREQ, WLOAD, XREQ, XLOAD, XFLUSH, SETTLE, ACC, DRAIN, DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [KW-1:0]   kij_q, kij_d;
  logic [KXW-1:0]  kx_q, kx_d, ky_q, ky_d;
  logic [PW-1:0]   nx_q, nx_d, ny_q, ny_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      kij_q   <= '0;
      kx_q    <= '0;
      ky_q    <= '0;
      nx_q    <= '0;
      ny_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      kij_q   <= kij_d;
      kx_q    <= kx_d;
      ky_q    <= ky_d;
      nx_q    <= nx_d;
      ny_q    <= ny_d;
    end
  end

  // cnt_q is a shared down-counter: oc in WLOAD, remaining cycles in XFLUSH/SETTLE/DRAIN
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    kij_d   = kij_q;
    kx_d    = kx_q;
    ky_d    = ky_q;
    nx_d    = nx_q;
    ny_d    = ny_q;
    unique case (state_q)
      IDLE: if (bus.start) begin
        state_d = WREQ;
        kij_d   = '0;
        kx_d    = '0;
        ky_d    = '0;
      end
      WREQ: if (bus.req[0]) begin
        state_d = WLOAD;
        cnt_d   = CW'(CHANNELS - 1);
      end
      WLOAD: if (cnt_q == '0) state_d = XREQ;
             else cnt_d = cnt_q - CW'(1);
      XREQ: if (bus.req[1]) begin
        state_d = XLOAD;
        nx_d    = '0;
        ny_d    = '0;
      end
      XLOAD: begin
        if (nx_q == PW'(LEN_NI_UNPAD - 1)) begin
          nx_d = '0;
          if (ny_q == PW'(LEN_NI_UNPAD - 1)) begin
            state_d = XFLUSH;
            cnt_d   = CW'(CHANNELS - 1);
          end else begin
            ny_d = ny_q + PW'(1);
          end
        end else begin
          nx_d = nx_q + PW'(1);
        end
      end
      XFLUSH: if (cnt_q == '0) begin
        state_d = SETTLE;
        cnt_d   = CW'(SETTLE_CYC - 1);
      end else cnt_d = cnt_q - CW'(1);
      SETTLE: begin
        if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
        else if (kij_q == KW'(KIJ_N - 1)) state_d = ACC;
        else begin
          state_d = WREQ;
          kij_d   = kij_q + KW'(1);
          if (kx_q == KXW'(LEN_KI - 1)) begin
            kx_d = '0;
            ky_d = ky_q + KXW'(1);
          end else begin
            kx_d = kx_q + KXW'(1);
          end
        end
      end
      ACC: begin
        state_d = DRAIN;
        cnt_d   = CW'(DRAIN_CYC - 1);
      end
      DRAIN: if (cnt_q == '0) state_d = DONE;
             else cnt_d = cnt_q - CW'(1);
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      kij_d   = '0;
      kx_d    = '0;
      ky_d    = '0;
      nx_d    = '0;
      ny_d    = '0;
    end
  end

  logic [1:0]  ack;
  logic        inst_wload, sfu_acc, cen, done;
  logic [10:0] addr;

  // Pure state/counter decode so no input reaches an output combinationally
  always_comb begin
    ack        = '0;
    inst_wload = 1'b0;
    sfu_acc    = 1'b0;
    cen        = 1'b1;
    done       = 1'b0;
    addr       = '0;
    unique case (state_q)
      WREQ:  inst_wload = 1'b1;
      WLOAD: begin
        ack[0] = 1'b1;
        cen    = 1'b0;
        addr   = W_BASE + 11'(kij_q) * 11'(CHANNELS) + 11'(cnt_q);
      end
      XLOAD: begin
        ack[1] = 1'b1;
        cen    = 1'b0;
        addr   = (11'(ny_q) + 11'(ky_q)) * 11'(LEN_NI) + 11'(nx_q) + 11'(kx_q);
      end
      XFLUSH:  ack[1]  = 1'b1;
      ACC:     sfu_acc = 1'b1;
      DONE:    done    = 1'b1;
      default: ;
    endcase
  end

  assign bus.ack        = ack;
  assign bus.inst_wload = inst_wload;
  assign bus.sfu_acc    = sfu_acc;
  assign bus.mem_CEN    = cen;
  assign bus.mem_WEN    = 1'b1;
  assign bus.mem_A      = addr;
  assign bus.busy       = (state_q != IDLE);
  assign bus.done       = done;
endmodule

// File: doc/conv_load_sched.md
CONV_LOAD_SCHED -- requirements
Module: conv_load_sched

Interface
REQ-001: Parameter LEN_NI, default 6, padded activation row length.
REQ-002: Parameter LEN_NI_UNPAD, default 4, unpadded output row length.
REQ-003: Parameter LEN_KI, default 3, kernel edge; kij runs 0..LEN_KI*LEN_KI-1.
REQ-004: Parameter CHANNELS, default 8, output channels per kij weight block.
REQ-005: Parameter W_BASE, default 11'h400, weight region base address.
REQ-006: Parameter SETTLE_CYC, default 20, idle cycles after each kij.
REQ-007: Parameter DRAIN_CYC, default 200, idle cycles after the accumulate pulse.
REQ-008: clk  input  1  sole clock; all state on rising edge.
REQ-009: reset  input  1  asynchronous, active-low reset.
REQ-010: start  input  1  begin one full convolution pass; sampled in IDLE only.
REQ-011: abort  input  1  synchronous return to IDLE from any state.
REQ-012: req  input  2  core ready: bit0 weight load, bit1 activation load.
REQ-013: ack  output  2  grant to core: bit0 weight stream, bit1 activation stream.
REQ-014: inst_wload  output  1  weight-load instruction to core (inst[4]).
REQ-015: sfu_acc  output  1  one-cycle SFU accumulate pulse (sfu_q[0]).
REQ-016: mem_CEN  output  1  SRAM chip enable, active-low.
REQ-017: mem_WEN  output  1  SRAM write enable, active-low; this block only reads.
REQ-018: mem_A  output  11  SRAM address.
REQ-019: busy  output  1  high in every state except IDLE.
REQ-020: done  output  1  one-cycle pulse when the pass completes.

Function
REQ-021: The FSM SHALL have states IDLE, WREQ, WLOAD, XREQ, XLOAD, XFLUSH, SETTLE, ACC, DRAIN and DONE.
REQ-022: Outputs SHALL decode only from state and counter registers, with no combinational path from any input to any output.
REQ-023: mem_WEN SHALL be constant 1.
REQ-024: mem_CEN SHALL be 0 only in WLOAD and XLOAD.
REQ-025: IDLE: when start=1, the FSM SHALL clear kij, kx and ky to 0 and move to WREQ; otherwise it stays in IDLE.
REQ-026: WREQ: inst_wload SHALL be 1, and the FSM SHALL move to WLOAD on the first edge where req[0]=1.
REQ-027: WLOAD: ack[0]=1; the block SHALL read for exactly CHANNELS cycles with mem_A = W_BASE + kij*CHANNELS + oc, oc descending from CHANNELS-1 to 0, then move to XREQ.
REQ-028: XREQ: all outputs SHALL be idle, and the FSM SHALL move to XLOAD on the first edge where req[1]=1.
REQ-029: XLOAD: ack[1]=1; the block SHALL read for exactly LEN_NI_UNPAD^2 cycles with mem_A = (ny+ky)*LEN_NI + (nx+kx), nx inner and ny outer, both from 0.
REQ-030: XFLUSH: ack[1] SHALL stay 1 with mem_CEN=1 for CHANNELS cycles, then the FSM SHALL move to SETTLE.
REQ-031: SETTLE: the FSM SHALL wait SETTLE_CYC cycles, then advance kx (wrapping at LEN_KI, carrying into ky) and go to WREQ, or go to ACC when kij = LEN_KI^2-1.
REQ-032: ACC: sfu_acc SHALL be 1 for exactly one cycle, then the FSM SHALL move to DRAIN.
REQ-033: DRAIN: the FSM SHALL wait DRAIN_CYC cycles, then go to DONE.
REQ-034: DONE: done SHALL be 1 for one cycle, then the FSM SHALL return to IDLE.
REQ-035: req changes after a stream has started SHALL be ignored; each stream runs its full length.
REQ-036: start while busy=1 SHALL be ignored and not queued.
REQ-037: abort SHALL take priority over all transitions, including a same-cycle start in IDLE; the next edge enters IDLE with all counters cleared.
REQ-038: Address arithmetic SHALL be computed at width 11; parameters SHALL be chosen so no address exceeds 2047.

Reset
REQ-039: While reset=0, the block SHALL be in IDLE with all counters 0, ack=0, inst_wload=0, sfu_acc=0, mem_CEN=1, mem_WEN=1, mem_A=0, busy=0 and done=0.
REQ-040: Reset asserted mid-stream SHALL abandon the pass immediately; after release the block waits for a new start.

Verification
REQ-041: Defaults, start pulse, core model returns req one cycle after each request -> 9 weight streams at 0x400+kij*8+{7..0}, 9 activation streams of 16 addresses; kij=0 reads 0,1,2,3,6,...,21; kij=8 reads 14..17, 20..23, 26..29, 32..35; exactly one sfu_acc; done follows 200 idle cycles.
REQ-042: Hold req[0]=0 for 50 cycles in WREQ -> inst_wload stays 1, mem_CEN stays 1, no address change; stream starts on the edge after req[0] rises.
REQ-043: Drop req[1] mid-XLOAD -> all 16 addresses are still issued consecutively; ack[1] stays 1 through the 8 XFLUSH cycles.
REQ-044: Pulse start during SETTLE of kij=4 -> ignored; exactly one done per pass.
REQ-045: abort in WLOAD at oc=3 -> next cycle IDLE with ack=0 and mem_CEN=1; a following start restarts at kij=0, address 0x407.
REQ-046: Assert reset in XLOAD -> outputs reach reset values asynchronously, before the next clk edge.
